lsu_byte_sequencer: RTL and testbench
=====================================

Name: lsu_byte_sequencer

Overview:
- Multi-cycle load/store controller between the exec stage and the byte-wide data memory.
- Accepts one RISC-V load/store per handshake: LB/LH/LW/LBU/LHU/SB/SH/SW, keyed by funct3 plus a store flag.
- Sequences the access as 1, 2 or 4 little-endian byte accesses on a single-port 8-bit memory with 1-cycle read latency.
- Returns sign- or zero-extended load data with a single-cycle response pulse.

Parameters:
ADDR_W, 3, byte-address width of data memory; depth is 2**ADDR_W bytes.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request; equal to (state==IDLE).
req_store  input  1  1=store, 0=load.
req_funct3  input  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
req_addr  input  32  effective address (rs1+imm), computed upstream.
req_wdata  input  32  store data; low bytes used.
resp_valid  output  1  one-cycle completion pulse.
resp_rdata  output  32  extended load data; 0 for stores and errors.
resp_err  output  1  illegal request; valid with resp_valid.
mem_en  output  1  memory access strobe.
mem_we  output  1  write enable, qualified by mem_en.
mem_addr  output  ADDR_W  byte address.
mem_wdata  output  8  write byte.
mem_rdata  input  8  read byte, valid the cycle after a read strobe.

Behaviour:
- Clock and reset: one clock (clk); reset asynchronous, active-low (rst_n).
- States: IDLE, ACCESS, CAPTURE, RESP.
- Reset values:
  - state=IDLE, byte counter=0, data register=0.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Memory-port outputs are combinational from state and counter, so assertion of rst_n drops mem_en immediately.
- IDLE:
  - req_ready=1; the request is accepted on a clk edge with req_valid=1 and rst_n=1.
  - Latch addr, wdata, funct3 and store; nbytes = 1/2/4 from funct3[1:0].
  - Illegal requests go to RESP with err=1 and perform no memory access:
    - funct3 in {011, 110, 111};
    - store with funct3[2]=1.
  - All legal requests go to ACCESS with counter i=0.
- ACCESS, one byte per cycle:
  - mem_en=1, mem_we=store.
  - mem_addr = (addr+i) mod 2**ADDR_W; addresses past the top wrap to 0.
  - mem_wdata = wdata[8i+7:8i].
  - Loads capture mem_rdata into byte lane i-1 when i>0.
  - At i=nbytes-1: a load goes to CAPTURE, a store goes to RESP.
- CAPTURE: mem_en=0; capture the final byte into lane nbytes-1; go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, with no back-pressure; then go to IDLE.
  - Load data is extended by the funct3[2]=0 sign rule from the top loaded byte.
- Latency, with acceptance at edge T:
  - load: resp_valid in cycle T+nbytes+2;
  - store: resp_valid in cycle T+nbytes+1;
  - illegal request: resp_valid in cycle T+1.
- Back-to-back: a new request can be accepted on the edge leaving RESP→IDLE+1, i.e. once req_ready reads 1 again.
- req_valid while not in IDLE is ignored; no queuing.
- Reset mid-operation:
  - abort immediately; no response is produced;
  - store bytes already written remain in memory.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A halfword access with addr[0]≠0 is rejected.
  - A word access with addr[1:0]≠0 is rejected.
  - Rejected accesses perform no memory access and go to RESP with resp_err=1, resp_rdata=0, latency T+1.
- Undefined: misaligned accesses complete normally, byte by byte, with address wrap.

Test Plan:
1. SW wdata=0xDEADBEEF, addr=4 → four mem_en cycles with mem_we=1 writing bytes 4..7 = EF,BE,AD,DE; resp_valid at T+5; resp_err=0; resp_rdata=0.
2. Memory byte 7 = 0x80.
   - LB addr=7 → resp_rdata=0xFFFFFF80 at T+3.
   - LBU addr=7 → resp_rdata=0x00000080.
3. Bytes 6,7 = 0x34,0x92.
   - LH addr=6 → resp_rdata=0xFFFF9234 at T+4.
   - LHU addr=6 → resp_rdata=0x00009234.
4. LW addr=6, ADDR_W=3, bytes 6,7,0,1 = 11,22,33,44.
   - Macro undefined → mem_addr sequence 6,7,0,1; resp_rdata=0x44332211 at T+6.
   - MISALIGN_TRAP_EN defined → no mem_en; resp_err=1 at T+1.
5. Illegal requests.
   - Load funct3=011 → resp_err=1, rdata=0 at T+1, no mem_en.
   - Store funct3=100 → same response.
   - req_valid held during a busy LW → ignored; exactly one response.
6. SW 0xA1B2C3D4 addr=0, rst_n asserted during the third ACCESS cycle → mem_en=0 immediately; no resp_valid; only bytes 0,1 = D4,C3 written; req_ready=1 after release.

Source files
------------

// File: rtl/lsu_byte_sequencer.sv
// -----------------------------------------------------------------------------
// lsu_byte_sequencer
//
// Multi-cycle load/store controller between the exec stage and a single-port,
// byte-wide data memory with one cycle of read latency. One RISC-V load/store
// (LB/LH/LW/LBU/LHU/SB/SH/SW) is accepted per handshake. It is carried out as
// 1, 2 or 4 little-endian byte accesses. Load data is returned sign- or
// zero-extended, together with a single-cycle response pulse.
//
// Optional feature (compile-time macro MISALIGN_TRAP_EN):
//   defined   - misaligned halfword/word requests are rejected with resp_err=1
//               and perform no memory access.
//   undefined - misaligned requests complete byte by byte; addresses wrap at
//               the top of the 2**ADDR_W byte memory.
//
// Parameters:
//   ADDR_W      byte-address width of the data memory (depth 2**ADDR_W bytes)
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   req_valid   request present
//   req_ready   block can accept a request (state is IDLE)
//   req_store   1 = store, 0 = load
//   req_funct3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   req_addr    effective byte address
//   req_wdata   store data, low bytes used
//   resp_valid  one-cycle completion pulse
//   resp_rdata  extended load data; 0 for stores and errors
//   resp_err    illegal request, valid with resp_valid
//   mem_en      memory access strobe
//   mem_we      write enable, qualified by mem_en
//   mem_addr    memory byte address
//   mem_wdata   write byte
//   mem_rdata   read byte, valid the cycle after a read strobe
// -----------------------------------------------------------------------------
module lsu_byte_sequencer #(
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t            state_r;
   logic [1:0]        cnt_r;
   logic [1:0]        last_r;
   logic [ADDR_W-1:0] addr_r;
   logic [31:0]       wdata_r;
   logic [31:0]       data_r;
   logic [2:0]        funct3_r;
   logic              store_r;
   logic              err_r;
   logic              resp_valid_r;
   logic              resp_err_r;
   logic [31:0]       resp_rdata_r;

   logic              illegal_s;
   logic              misalign_s;
   logic              unused_addr_s;

   // Memory depth is 2**ADDR_W; the upper address bits have no effect.
   assign unused_addr_s = ^req_addr[31:ADDR_W];

   // Index of the final byte of the access: 0, 1 or 3.
   function automatic logic [1:0] last_index(input logic [1:0] size);
      logic [1:0] idx;
      case (size)
         2'b00:   idx = 2'd0;
         2'b01:   idx = 2'd1;
         default: idx = 2'd3;
      endcase
      return idx;
   endfunction

   // Sign extension when funct3[2]=0, zero extension when funct3[2]=1.
   function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                               input logic [2:0]  f3);
      logic [31:0] ext;
      case (f3[1:0])
         2'b00:   ext = {{24{~f3[2] & raw[7]}},  raw[7:0]};
         2'b01:   ext = {{16{~f3[2] & raw[15]}}, raw[15:0]};
         default: ext = raw;
      endcase
      return ext;
   endfunction

   // Decode the funct3/store combinations that have no legal meaning.
   always_comb begin
      illegal_s = 1'b0;
      case (req_funct3)
         3'b000, 3'b001, 3'b010: illegal_s = 1'b0;
         3'b100, 3'b101:         illegal_s = req_store;   // no unsigned stores
         default:                illegal_s = 1'b1;
      endcase
   end

   // Alignment check; active only when misalignment traps are built in.
   always_comb begin
      misalign_s = 1'b0;
`ifdef MISALIGN_TRAP_EN
      case (req_funct3[1:0])
         2'b01:   misalign_s = req_addr[0];
         2'b10:   misalign_s = |req_addr[1:0];
         default: misalign_s = 1'b0;
      endcase
`else
      misalign_s = 1'b0;
`endif
   end

   // Sequencer FSM: request latching, byte capture and the registered response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         cnt_r        <= 2'd0;
         last_r       <= 2'd0;
         addr_r       <= {ADDR_W{1'b0}};
         wdata_r      <= 32'd0;
         data_r       <= 32'd0;
         funct3_r     <= 3'd0;
         store_r      <= 1'b0;
         err_r        <= 1'b0;
         resp_valid_r <= 1'b0;
         resp_err_r   <= 1'b0;
         resp_rdata_r <= 32'd0;
      end else begin
         // The response registers pulse for exactly one cycle.
         resp_valid_r <= 1'b0;
         resp_err_r   <= 1'b0;
         resp_rdata_r <= 32'd0;
         case (state_r)
            IDLE: begin
               if (req_valid) begin
                  addr_r   <= req_addr[ADDR_W-1:0];
                  wdata_r  <= req_wdata;
                  funct3_r <= req_funct3;
                  store_r  <= req_store;
                  last_r   <= last_index(req_funct3[1:0]);
                  cnt_r    <= 2'd0;
                  data_r   <= 32'd0;
                  if (illegal_s || misalign_s) begin
                     err_r   <= 1'b1;
                     state_r <= RESP;
                  end else begin
                     err_r   <= 1'b0;
                     state_r <= ACCESS;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            ACCESS: begin
               // The byte read in the previous cycle is on mem_rdata now.
               if (!store_r && (cnt_r != 2'd0)) begin
                  data_r[{cnt_r - 2'd1, 3'b000} +: 8] <= mem_rdata;
               end else begin
                  data_r <= data_r;
               end
               if (cnt_r == last_r) begin
                  state_r <= store_r ? RESP : CAPTURE;
               end else begin
                  cnt_r <= cnt_r + 2'd1;
               end
            end
            CAPTURE: begin
               data_r[{last_r, 3'b000} +: 8] <= mem_rdata;
               state_r <= RESP;
            end
            RESP: begin
               resp_valid_r <= 1'b1;
               resp_err_r   <= err_r;
               if (err_r || store_r) begin
                  resp_rdata_r <= 32'd0;
               end else begin
                  resp_rdata_r <= extend_load(data_r, funct3_r);
               end
               state_r <= IDLE;
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   // Memory port is decoded from state and counter so reset drops it at once.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = 8'd0;
      if (state_r == ACCESS) begin
         mem_en    = 1'b1;
         mem_we    = store_r;
         mem_addr  = addr_r + ADDR_W'(cnt_r);   // wraps modulo 2**ADDR_W
         mem_wdata = wdata_r[{cnt_r, 3'b000} +: 8];
      end else begin
         mem_en    = 1'b0;
      end
   end

   assign req_ready  = (state_r == IDLE);
   assign resp_valid = resp_valid_r;
   assign resp_err   = resp_err_r;
   assign resp_rdata = resp_rdata_r;

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lsu_byte_sequencer
//
// Directed bench for lsu_byte_sequencer (ADDR_W=3) with an 8-byte memory model
// behind the memory port. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_lsu_byte_sequencer;

   localparam int ADDR_W = 3;

   logic              clk;
   logic              rst_n;
   logic              req_valid;
   logic              req_ready;
   logic              req_store;
   logic [2:0]        req_funct3;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   logic [7:0]        mem [0:7];
   logic              bd_we;
   logic [2:0]        bd_addr;
   logic [7:0]        bd_data;

   int errors;
   int checks;

   lsu_byte_sequencer #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_store  (req_store),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte memory with one-cycle read latency plus a backdoor write port.
   always @(posedge clk) begin
      if (bd_we) begin
         mem[bd_addr] <= bd_data;
      end else if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bd_write(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      bd_we   = 1'b1;
      bd_addr = a;
      bd_data = d;
      @(negedge clk);
      bd_we   = 1'b0;
   endtask

   // Issue one request and observe 11 cycles from the accepting edge.
   task automatic run_req(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int hold, input int exp_lat,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_en, input logic [31:0] exp_seq);
      int          lat;
      int          pulses;
      int          en_cnt;
      int          we_cnt;
      logic [31:0] seq;
      logic [31:0] rd;
      logic        er;
      lat = -1; pulses = 0; en_cnt = 0; we_cnt = 0;
      seq = 32'd0; rd = 32'd0; er = 1'b0;
      @(negedge clk);
      check_val({tag, " ready"}, {31'd0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_store  = st;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      @(posedge clk);
      for (int k = 0; k <= 10; k++) begin
         @(negedge clk);
         if (mem_en) begin
            if (en_cnt < 4) seq[8*en_cnt +: 8] = 8'(mem_addr);
            en_cnt++;
            if (mem_we) we_cnt++;
         end
         if (resp_valid) begin
            pulses++;
            if (lat < 0) begin
               lat = k;
               rd  = resp_rdata;
               er  = resp_err;
            end
         end
         if (k >= hold - 1) req_valid = 1'b0;
      end
      check_val({tag, " latency"}, lat, exp_lat);
      check_val({tag, " pulses"}, pulses, 32'd1);
      check_val({tag, " rdata"}, rd, exp_rdata);
      check_val({tag, " err"}, {31'd0, er}, {31'd0, exp_err});
      check_val({tag, " mem_en cycles"}, en_cnt, exp_en);
      check_val({tag, " mem_we cycles"}, we_cnt, st ? exp_en : 0);
      if (exp_en > 0) check_val({tag, " addr seq"}, seq, exp_seq);
   endtask

   initial begin
      int resp_seen;
      errors = 0; checks = 0;
      rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0;
      bd_we = 1'b0; bd_addr = 3'd0; bd_data = 8'd0;

      // Reset state
      repeat (2) @(negedge clk);
      check_val("rst resp_valid", {31'd0, resp_valid}, 32'd0);
      check_val("rst resp_err",   {31'd0, resp_err},   32'd0);
      check_val("rst resp_rdata", resp_rdata,          32'd0);
      check_val("rst mem_en",     {31'd0, mem_en},     32'd0);
      check_val("rst mem_we",     {31'd0, mem_we},     32'd0);
      check_val("rst mem_addr",   {29'd0, mem_addr},   32'd0);
      check_val("rst mem_wdata",  {24'd0, mem_wdata},  32'd0);
      check_val("rst req_ready",  {31'd0, req_ready},  32'd1);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) bd_write(3'(i), 8'h00);

      // SW to bytes 4..7
      run_req("sw4", 1'b1, 3'b010, 32'd4, 32'hDEADBEEF, 1, 5, 32'd0, 1'b0, 4, 32'h07060504);
      check_val("sw4 mem", {mem[7], mem[6], mem[5], mem[4]}, 32'hDEADBEEF);

      // Byte loads of 0x80
      run_req("sb7", 1'b1, 3'b000, 32'd7, 32'h00000080, 1, 2, 32'd0, 1'b0, 1, 32'h00000007);
      check_val("sb7 mem", {24'd0, mem[7]}, 32'h00000080);
      run_req("lb7",  1'b0, 3'b000, 32'd7, 32'd0, 1, 3, 32'hFFFFFF80, 1'b0, 1, 32'h00000007);
      run_req("lbu7", 1'b0, 3'b100, 32'd7, 32'd0, 1, 3, 32'h00000080, 1'b0, 1, 32'h00000007);

      // Halfword 0x9234 at 6
      run_req("sh6",  1'b1, 3'b001, 32'd6, 32'h00009234, 1, 3, 32'd0, 1'b0, 2, 32'h00000706);
      run_req("lh6",  1'b0, 3'b001, 32'd6, 32'd0, 1, 4, 32'hFFFF9234, 1'b0, 2, 32'h00000706);
      run_req("lhu6", 1'b0, 3'b101, 32'd6, 32'd0, 1, 4, 32'h00009234, 1'b0, 2, 32'h00000706);

      // Misaligned word wrapping the top of memory
      bd_write(3'd6, 8'h11);
      bd_write(3'd7, 8'h22);
      bd_write(3'd0, 8'h33);
      bd_write(3'd1, 8'h44);
`ifdef MISALIGN_TRAP_EN
      run_req("lw6", 1'b0, 3'b010, 32'd6, 32'd0, 1, 1, 32'd0, 1'b1, 0, 32'd0);
`else
      run_req("lw6", 1'b0, 3'b010, 32'd6, 32'd0, 1, 6, 32'h44332211, 1'b0, 4, 32'h01000706);
`endif

      // Illegal requests and a busy LW with req_valid held
      run_req("ld011", 1'b0, 3'b011, 32'd0, 32'd0, 1, 1, 32'd0, 1'b1, 0, 32'd0);
      run_req("st100", 1'b1, 3'b100, 32'd0, 32'hFFFFFFFF, 1, 1, 32'd0, 1'b1, 0, 32'd0);
      check_val("st100 mem0", {24'd0, mem[0]}, 32'h00000033);
      run_req("lw0 busy", 1'b0, 3'b010, 32'd0, 32'd0, 5, 6, 32'h00004433, 1'b0, 4, 32'h03020100);

      // SW aborted by reset in its third ACCESS cycle
      @(negedge clk);
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'd0; req_wdata = 32'hA1B2C3D4;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check_val("abort acc0 en", {31'd0, mem_en}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      check_val("abort acc2 addr", {31'd0, mem_en, mem_addr}, 32'h0000000A);
      rst_n = 1'b0;
      #1;
      check_val("abort mem_en", {31'd0, mem_en}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      resp_seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (resp_valid) resp_seen++;
      end
      check_val("abort no resp", resp_seen, 32'd0);
      check_val("abort ready", {31'd0, req_ready}, 32'd1);
      check_val("abort mem", {mem[3], mem[2], mem[1], mem[0]}, 32'h0000C3D4);

      // Operational again after reset
      run_req("lbu0", 1'b0, 3'b100, 32'd0, 32'd0, 1, 3, 32'h000000D4, 1'b0, 1, 32'h00000000);
      run_req("lb1",  1'b0, 3'b000, 32'd1, 32'd0, 1, 3, 32'hFFFFFFC3, 1'b0, 1, 32'h00000001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
